blink_monitor: RTL

BLINK_MONITOR -- requirements
Module: blink_monitor

---
 rtl/blink_monitor_pkg.sv | 4 +
 rtl/blink_monitor_sync_edge.sv | 14 +
 rtl/blink_monitor.sv | 89 ++++++++
 3 files changed

// File: rtl/blink_monitor_pkg.sv
// blink_monitor_pkg: FSM state encoding shared by the monitor and its bench
package blink_monitor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, TRACK = 2'd2} state_e;
endpackage

// File: rtl/blink_monitor_sync_edge.sv
// sync_edge: two-flop synchronizer plus delay stage; flags a transition of d
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic edge_pulse
);
  logic [2:0] sh_q;
  // bits 0..1 synchronize d, bit 2 delays the synchronized value by one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else sh_q <= {sh_q[1:0], d};
  assign edge_pulse = sh_q[2] ^ sh_q[1];
endmodule

// File: rtl/blink_monitor.sv
// blink_monitor: measures half-periods of a toggling signal and tracks lock/error
module blink_monitor
  import blink_monitor_pkg::*;
#(
  parameter int FREQ = 50_000_000,
  parameter int TOL = FREQ / 100,
  parameter int LOCK_N = 2,
  localparam int CW = $clog2(FREQ + TOL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          signal_in,
  input  logic          clr_err,
  output logic          edge_pulse,
  output logic [CW-1:0] half_period,
  output logic          period_valid,
  output logic          lock,
  output logic          err
);
  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [CW-1:0] LO = CW'(FREQ - TOL);
  localparam logic [CW-1:0] HI = CW'(FREQ + TOL);
  localparam logic [CW-1:0] TMO = CW'(FREQ + TOL - 1);
  localparam logic [GW-1:0] GMAX = GW'(LOCK_N);
  state_e state_q;
  logic [CW-1:0] cnt_q, half_q;
  logic [GW-1:0] good_q;
  logic edge_q, pv_q, lock_q, err_q;
  logic edge_w, in_win;
  logic [CW-1:0] meas_d;
  logic [GW-1:0] good_d;
  sync_edge u_sync (.clk(clk), .rst_n(rst_n), .d(signal_in), .edge_pulse(edge_w));
  assign meas_d = cnt_q + CW'(1);
  assign in_win = meas_d >= LO && meas_d <= HI;
  assign good_d = good_q == GMAX ? good_q : good_q + GW'(1);
  // the FSM sees the edge in the same cycle it is registered onto edge_pulse,
  // so period_valid lines up with edge_pulse; an error later in the block overrides clr_err
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      half_q <= '0;
      good_q <= '0;
      edge_q <= 1'b0;
      pv_q <= 1'b0;
      lock_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      edge_q <= edge_w;
      pv_q <= 1'b0;
      if (clr_err) err_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        cnt_q <= '0;
        good_q <= '0;
        lock_q <= 1'b0;
      end else
        case (state_q)
          IDLE: state_q <= ARM;
          ARM:
            if (edge_w) begin
              state_q <= TRACK;
              cnt_q <= '0;
            end
          TRACK:
            if (edge_w) begin
              cnt_q <= '0;
              half_q <= meas_d;
              pv_q <= 1'b1;
              good_q <= in_win ? good_d : '0;
              lock_q <= in_win && good_d == GMAX;
              if (!in_win) err_q <= 1'b1;
            end else if (cnt_q == TMO) begin
              state_q <= ARM;
              cnt_q <= '0;
              good_q <= '0;
              lock_q <= 1'b0;
              err_q <= 1'b1;
            end else cnt_q <= cnt_q + CW'(1);
          default: state_q <= IDLE;
        endcase
    end
  assign edge_pulse = edge_q;
  assign half_period = half_q;
  assign period_valid = pv_q;
  assign lock = lock_q;
  assign err = err_q;
endmodule
